freq_divider_multi: RTL

Parametrised, multi-channel successor to the fixed 2 Hz/4 Hz dividers. It generates NUM_CH independent square-wave clocks from the system clock. Each channel's half-period is runtime-programmable and updates glitch-free at the channel's next terminal count. The block feeds display scan, blink and debounce logic in the display-control path.

---
 rtl/freq_div_pkg.sv | 29 ++
 rtl/freq_divider_multi_if.sv | 37 +++
 rtl/freq_div_channel.sv | 89 ++++++++
 rtl/freq_divider_multi.sv | 55 +++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Purpose: shared constants and helpers for the multi-channel clock divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default input clock rate, default half-period, common
// half-period values at 100 MHz, and width/half-period helper functions.
package freq_div_pkg;

   localparam int unsigned DEF_CLK_HZ = 100_000_000;
   localparam int unsigned DEF_HALF   = 24_999_999;   // 2 Hz at 100 MHz

   // Half-period minus one for common rates at 100 MHz.
   localparam int unsigned HALF_1HZ   = 49_999_999;
   localparam int unsigned HALF_2HZ   = 24_999_999;
   localparam int unsigned HALF_4HZ   = 12_499_999;
   localparam int unsigned HALF_1KHZ  = 49_999;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Half-period minus one for a given output rate.
   function automatic int unsigned half_for(input int unsigned clk_hz,
                                            input int unsigned out_hz);
      return clk_hz / (2 * out_hz) - 1;
   endfunction

endpackage

// File: rtl/freq_divider_multi_if.sv
// Purpose: configuration / control / output bundle of the multi-channel divider.
// Latency: n/a (wiring only).
// Backpressure: none; writes are fire-and-forget, cfg_busy_o reports pending shadows.
//
// Signals: cfg_we_i/cfg_ch_i/cfg_half_i (half-period write), en_i (per-channel
// run), sync_i (phase-align all), cfg_busy_o, clk_o, and tick_o when the
// FREQ_DIV_TICK_EN macro is defined.
interface freq_divider_multi_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 28
);
   import freq_div_pkg::*;

   localparam int CH_W = ch_width(NUM_CH);

   logic              cfg_we_i;
   logic [CH_W-1:0]   cfg_ch_i;
   logic [CNT_W-1:0]  cfg_half_i;
   logic [NUM_CH-1:0] en_i;
   logic              sync_i;
   logic [NUM_CH-1:0] cfg_busy_o;
   logic [NUM_CH-1:0] clk_o;
`ifdef FREQ_DIV_TICK_EN
   logic [NUM_CH-1:0] tick_o;

   modport master (output cfg_we_i, cfg_ch_i, cfg_half_i, en_i, sync_i,
                   input  cfg_busy_o, clk_o, tick_o);
   modport slave  (input  cfg_we_i, cfg_ch_i, cfg_half_i, en_i, sync_i,
                   output cfg_busy_o, clk_o, tick_o);
`else
   modport master (output cfg_we_i, cfg_ch_i, cfg_half_i, en_i, sync_i,
                   input  cfg_busy_o, clk_o);
   modport slave  (input  cfg_we_i, cfg_ch_i, cfg_half_i, en_i, sync_i,
                   output cfg_busy_o, clk_o);
`endif

endinterface

// File: rtl/freq_div_channel.sv
// Purpose: one divider channel - counter, shadow/pending half-period, output toggle.
// Latency: o_clk toggles one cycle after the terminal compare; o_busy follows a write by one cycle.
// Backpressure: none; a write while pending overwrites the shadow (last write wins).
//
// Ports: i_clk, i_rst_n (async, active low), i_wr/i_wr_half (shadow write),
// i_en (run), i_sync (phase align), o_busy (shadow pending), o_clk (divided
// clock), o_tick (rising-edge pulse, only with FREQ_DIV_TICK_EN).
module freq_div_channel #(
   parameter int          CNT_W        = 28,
   parameter int unsigned DEFAULT_HALF = 24_999_999
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_wr_half,
   input  logic             i_en,
   input  logic             i_sync,
   output logic             o_busy,
`ifdef FREQ_DIV_TICK_EN
   output logic             o_tick,
`endif
   output logic             o_clk
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_half;
   logic [CNT_W-1:0] r_shadow;
   logic             r_pend;
   logic             r_clk;

   logic             w_term;
   logic             w_run;
   logic             w_apply;

   assign w_term  = (r_cnt == r_half);
   assign w_run   = i_en && !i_sync;
   // Any point where the active half may change: terminal, disable, or sync.
   assign w_apply = !w_run || w_term;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_half   <= CNT_W'(DEFAULT_HALF);
         r_shadow <= CNT_W'(DEFAULT_HALF);
         r_pend   <= 1'b0;
         r_clk    <= 1'b0;
      end else begin
         if (!w_run) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
         end else if (w_term) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         // The apply point sees the shadow as it was before this cycle's write.
         if (w_apply && r_pend)
            r_half <= r_shadow;

         // A write coinciding with an apply point stays pending for the next one.
         if (i_wr) begin
            r_shadow <= i_wr_half;
            r_pend   <= 1'b1;
         end else if (w_apply) begin
            r_pend   <= 1'b0;
         end
      end
   end

`ifdef FREQ_DIV_TICK_EN
   logic r_tick;

   // Terminal while low is the rising toggle, so the pulse lines up with o_clk rising.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_tick <= 1'b0;
      else
         r_tick <= w_run && w_term && !r_clk;
   end

   assign o_tick = r_tick;
`endif

   assign o_busy = r_pend;
   assign o_clk  = r_clk;

endmodule

// File: rtl/freq_divider_multi.sv
// Purpose: NUM_CH independent runtime-programmable square-wave dividers with glitch-free retune.
// Latency: outputs are flops; clk_o first rises half+1 cycles after en_i, cfg_busy_o one cycle after a write.
// Backpressure: none; a write to cfg_ch_i >= NUM_CH is dropped, repeated writes overwrite the shadow.
//
// Ports: clk_i, rst_i (async, active low), bus (freq_divider_multi_if.slave).
// Optional feature: define FREQ_DIV_TICK_EN to add the per-channel tick_o pulse.
module freq_divider_multi
   import freq_div_pkg::*;
#(
   parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
   parameter int          NUM_CH       = 4,
   parameter int          CNT_W        = 28,
   parameter int unsigned DEFAULT_HALF = half_for(CLK_HZ, 2)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   freq_divider_multi_if.slave bus
);

   logic [NUM_CH-1:0] w_wr;
   logic [NUM_CH-1:0] w_busy;
   logic [NUM_CH-1:0] w_clk;
`ifdef FREQ_DIV_TICK_EN
   logic [NUM_CH-1:0] w_tick;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      // Out-of-range selects never match any channel index, so they are dropped.
      assign w_wr[c] = bus.cfg_we_i && (int'(bus.cfg_ch_i) == c);

      freq_div_channel #(
         .CNT_W        (CNT_W),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_ch (
         .i_clk     (clk_i),
         .i_rst_n   (rst_i),
         .i_wr      (w_wr[c]),
         .i_wr_half (bus.cfg_half_i),
         .i_en      (bus.en_i[c]),
         .i_sync    (bus.sync_i),
         .o_busy    (w_busy[c]),
`ifdef FREQ_DIV_TICK_EN
         .o_tick    (w_tick[c]),
`endif
         .o_clk     (w_clk[c])
      );
   end

   assign bus.cfg_busy_o = w_busy;
   assign bus.clk_o      = w_clk;
`ifdef FREQ_DIV_TICK_EN
   assign bus.tick_o     = w_tick;
`endif

endmodule
